tmr_error_monitor: RTL
======================

# tmr_error_monitor

Error-event monitor that sits directly downstream of the triple-redundant NAND flash controller (three NFC copies plus per-signal TMR/simplex voters). It consumes the per-voter disagreement flags and the controller's `done`. It turns level-type error flags into counted events, captures the first offending voter and its timestamp, raises an acknowledged interrupt, and declares the controller degraded once a cumulative event threshold is reached.

## Interface
Parameters:
- `N_SRC`, 13: number of voter error sources; one per voted controller output.
- `CNT_W`, 8: width of the total event counter, saturating.
- `TS_W`, 16: width of the free-running timestamp, saturating.
- `THRESH`, 4: event count at which `degraded` sets. Legal range is 1 to 2^CNT_W−1.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-low reset.
- `err_vec`, in, N_SRC: per-voter error flags. Bit i is voter i (0=done, 1=IO_A, …, 12=IO_B_READING). Level-sensitive.
- `done_in`, in, 1: registered `done` from the controller.
- `clr`, in, 1: single-cycle clear of all captured status.
- `irq_ack`, in, 1: interrupt acknowledge.
- `irq`, out, 1: pending-event interrupt.
- `sticky`, out, N_SRC: OR of every rising edge seen per source since the last clear.
- `evt_cnt`, out, CNT_W: total rising-edge events, saturating.
- `first_src`, out, 4: index of the first source to fire. The lowest index wins a tie.
- `first_ts`, out, TS_W: timestamp of the first event.
- `first_vld`, out, 1: `first_src` and `first_ts` are valid.
- `degraded`, out, 1: `evt_cnt` ≥ THRESH.
- `summary_vld`, out, 1: one-cycle pulse when the run completes.

## Operation
- `err_q` holds `err_vec` from the previous cycle. `rise = err_vec & ~err_q`. A flag held high counts once. A flag that drops and re-rises counts again.
- `evt_cnt` update: `evt_cnt ← min(evt_cnt + popcount(rise), 2^CNT_W−1)`. The add is done at CNT_W+1 bits, then saturated.
- Timestamp `ts`: starts at 0 after reset and increments every cycle. It saturates at all-ones and does not wrap. It is cleared only by reset, not by `clr`.
- First capture: on the first cycle where `rise≠0` while `first_vld=0`, load `first_src` with the lowest set index of `rise`, load `first_ts` with `ts`, and set `first_vld`.
- State machine states: IDLE, PEND, DEGR.
  - IDLE → PEND when `rise≠0`.
  - PEND → IDLE when `irq_ack=1` and `rise=0`.
  - IDLE or PEND → DEGR when the next `evt_cnt` value ≥ THRESH. This transition has priority.
  - DEGR is left only through `clr` or reset.
- `irq` is high in PEND and in DEGR.
- `irq_ack` in DEGR has no effect.
- `degraded` is 1 only in DEGR.
- `clr`:
  - zeroes `sticky`, `evt_cnt`, `first_*`, and `err_q`-independent status;
  - returns the state to IDLE.
  - If `rise≠0` in the same cycle, `clr` applies first and the events are then recorded into the fresh state: `evt_cnt = popcount(rise)`, new first capture, state PEND (or DEGR if popcount ≥ THRESH).
- `irq_ack` and a new rise in the same cycle: the state stays PEND and `irq` remains high.
- `summary_vld` pulses for one cycle on the rising edge of `done_in`. It is independent of the state machine.

## Timing
- All outputs are registered.
- Latency: if `err_vec` rises before clock edge k, then `sticky`, `evt_cnt`, `first_*` and `irq` reflect it immediately after edge k. That is one cycle.
- `irq` deasserts the cycle after an accepted `irq_ack`.
- `summary_vld` is high the cycle after `done_in` is first sampled high.
- Reset values:
  - `irq=0`, `sticky=0`, `evt_cnt=0`, `first_src=0`, `first_ts=0`, `first_vld=0`, `degraded=0`, `summary_vld=0`;
  - `err_q=0`, `ts=0`, state IDLE.
- An `err_vec` bit that is already high when reset releases counts as a rise on the first post-reset edge.
- Reset mid-operation discards all status in the same edge. `rst` dominates `clr`.

## Structure
- Package `tmr_mon_pkg` holds:
  - the state enum (IDLE, PEND, DEGR);
  - the constant `N_SRC_DEF=13`;
  - the localparam source indices for the 13 voted signals.
- Sub-module `tmr_err_popcount`: combinational popcount of N_SRC bits plus lowest-set-index encoder. It outputs the count (clog2(N_SRC+1) bits), the index, and an any-set flag.
- The top holds the edge register, counters, timestamp, and state machine.

## Test plan
- Reset, then `err_vec=0` for 20 cycles. Required: all outputs 0, state IDLE, `irq=0`.
- Cycle 10: `err_vec[3]` rises and is held high for 5 cycles. Required:
  - `evt_cnt=1`, `sticky=0x0008`, `first_src=3`, `first_ts=10`, `irq=1`;
  - the held level does not re-count.
  - Pulse `irq_ack`: `irq=0` next cycle.
- `err_vec` bits 5 and 2 rise in the same cycle from the clear state. Required: `evt_cnt=2`, `first_src=2`.
- With THRESH=4, drive four separate one-cycle pulses on bit 0. Required:
  - `degraded=1` and `irq=1` right after the 4th edge;
  - `irq_ack` is ignored;
  - `clr` returns the block to IDLE with `evt_cnt=0`.
- `clr` asserted in the same cycle as a bit 7 rise. Required: `evt_cnt=1`, `sticky=0x0080`, `first_src=7`, state PEND.
- With CNT_W=4, drive 20 pulses: `evt_cnt` saturates at 15. Then `done_in` 0→1: `summary_vld` high for exactly one cycle.

Source files
------------

// File: rtl/tmr_mon_pkg.sv
// Shared types and constants for the TMR voter error monitor.
// Source indices follow the voter ordering of the triple-redundant NAND controller.
package tmr_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DEGR = 2'd2
    } mon_state_t;

    localparam int N_SRC_DEF = 13;

    localparam int SRC_DONE         = 0;
    localparam int SRC_IO_A         = 1;
    localparam int SRC_IO_A_OE      = 2;
    localparam int SRC_CLE_A        = 3;
    localparam int SRC_ALE_A        = 4;
    localparam int SRC_WE_A_N       = 5;
    localparam int SRC_RE_A_N       = 6;
    localparam int SRC_CE_A_N       = 7;
    localparam int SRC_IO_B         = 8;
    localparam int SRC_IO_B_OE      = 9;
    localparam int SRC_CLE_B        = 10;
    localparam int SRC_ALE_B        = 11;
    localparam int SRC_IO_B_READING = 12;

endpackage

// File: rtl/tmr_err_popcount.sv
// Combinational popcount plus lowest-set-index encoder over the per-cycle rise vector.
// o_idx is 4 bits wide, matching the first-source capture register in the top.
module tmr_err_popcount
    import tmr_mon_pkg::*;
#(
    parameter int N         = N_SRC_DEF,
    parameter int CNT_OUT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]         i_vec,
    output logic [CNT_OUT_W-1:0] o_cnt,
    output logic [3:0]           o_idx,
    output logic                 o_any
);

    always_comb begin
        o_cnt = '0;
        o_idx = '0;
        o_any = |i_vec;
        // Scan downward so the last hit, the lowest index, wins.
        for (int i = N - 1; i >= 0; i--) begin
            o_cnt = o_cnt + CNT_OUT_W'(i_vec[i]);
            if (i_vec[i]) o_idx = 4'(i);
        end
    end

endmodule

// File: rtl/tmr_error_monitor.sv
// Counts rising edges of voter disagreement flags, captures the first offender and its
// timestamp, raises an acknowledged interrupt, and latches a degraded state at THRESH events.
//
// state | meaning
// IDLE  | no unacknowledged event
// PEND  | event seen, irq high until acknowledged
// DEGR  | cumulative events reached THRESH; irq held, left only via clr or reset
module tmr_error_monitor
    import tmr_mon_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int CNT_W  = 8,
    parameter int TS_W   = 16,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] err_vec,
    input  logic             done_in,
    input  logic             clr,
    input  logic             irq_ack,
    output logic             irq,
    output logic [N_SRC-1:0] sticky,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [3:0]       first_src,
    output logic [TS_W-1:0]  first_ts,
    output logic             first_vld,
    output logic             degraded,
    output logic             summary_vld
);

    localparam int PC_W = $clog2(N_SRC + 1);

    logic [N_SRC-1:0] r_err_q;
    logic [TS_W-1:0]  r_ts;
    mon_state_t       r_state;
    logic [N_SRC-1:0] r_sticky;
    logic [CNT_W-1:0] r_evt_cnt;
    logic [3:0]       r_first_src;
    logic [TS_W-1:0]  r_first_ts;
    logic             r_first_vld;
    logic             r_irq;
    logic             r_degraded;
    logic             r_done_q;
    logic             r_summary_vld;

    logic [N_SRC-1:0] w_rise;
    logic [PC_W-1:0]  w_pcnt;
    logic [3:0]       w_low_idx;
    logic             w_any;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_first_held;
    mon_state_t       w_state_base;
    mon_state_t       w_state_nxt;

    assign w_rise = err_vec & ~r_err_q;

    tmr_err_popcount #(.N(N_SRC), .CNT_OUT_W(PC_W)) u_popcount (
        .i_vec (w_rise),
        .o_cnt (w_pcnt),
        .o_idx (w_low_idx),
        .o_any (w_any)
    );

    // clr wipes status first, so same-cycle rises land in a fresh record.
    assign w_cnt_base   = clr ? '0 : r_evt_cnt;
    assign w_sum        = {1'b0, w_cnt_base} + (CNT_W + 1)'(w_pcnt);
    assign w_cnt_nxt    = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_first_held = r_first_vld && !clr;
    assign w_state_base = clr ? ST_IDLE : r_state;

    always_comb begin
        w_state_nxt = w_state_base;
        if (w_state_base != ST_DEGR) begin
            if (w_cnt_nxt >= CNT_W'(THRESH))
                w_state_nxt = ST_DEGR;
            else if (w_any)
                w_state_nxt = ST_PEND;
            else if (w_state_base == ST_PEND && irq_ack)
                w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_q       <= '0;
            r_ts          <= '0;
            r_state       <= ST_IDLE;
            r_sticky      <= '0;
            r_evt_cnt     <= '0;
            r_first_src   <= '0;
            r_first_ts    <= '0;
            r_first_vld   <= 1'b0;
            r_irq         <= 1'b0;
            r_degraded    <= 1'b0;
            r_done_q      <= 1'b0;
            r_summary_vld <= 1'b0;
        end else begin
            r_err_q       <= err_vec;
            r_ts          <= (r_ts == {TS_W{1'b1}}) ? r_ts : r_ts + 1'b1;
            r_state       <= w_state_nxt;
            r_sticky      <= (clr ? '0 : r_sticky) | w_rise;
            r_evt_cnt     <= w_cnt_nxt;
            r_irq         <= (w_state_nxt != ST_IDLE);
            r_degraded    <= (w_state_nxt == ST_DEGR);
            r_done_q      <= done_in;
            r_summary_vld <= done_in && !r_done_q;
            if (w_any && !w_first_held) begin
                r_first_src <= w_low_idx;
                r_first_ts  <= r_ts;
                r_first_vld <= 1'b1;
            end else if (clr) begin
                r_first_src <= '0;
                r_first_ts  <= '0;
                r_first_vld <= 1'b0;
            end
        end
    end

    assign irq         = r_irq;
    assign sticky      = r_sticky;
    assign evt_cnt     = r_evt_cnt;
    assign first_src   = r_first_src;
    assign first_ts    = r_first_ts;
    assign first_vld   = r_first_vld;
    assign degraded    = r_degraded;
    assign summary_vld = r_summary_vld;

endmodule
